// File: rtl/io_mem_bank.sv
// Ping-pong I/O sample memory responding on the dsp_core io_mem bus.
// Optional sticky status flags are built only when IO_MEM_STATUS_EN is defined.
module io_mem_bank #(
   parameter int DATA_W = 36,
   parameter int ADDR_W = 10,
   parameter int N_CH   = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              frame_sync,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              err_in_short,
   output logic              err_out_late,
   input  logic              err_clr
);

   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_W = $clog2(N_CH + 1);
   localparam logic [CNT_W-1:0]  N_CH_C = CNT_W'(N_CH);
   localparam logic [ADDR_W:0]   N_CH_A = (ADDR_W + 1)'(N_CH);

   // Bank pairs indexed by the select bit: [bank][channel].
   logic [DATA_W-1:0] r_in_mem  [2][N_CH];
   logic [DATA_W-1:0] r_out_mem [2][N_CH];

   logic              r_sel;
   logic [CNT_W-1:0]  r_in_cnt;
   logic [CNT_W-1:0]  r_out_cnt;
   logic              r_drain_active;
   logic [DATA_W-1:0] r_rd_data;

   logic              w_aud_sel;
   logic              w_rd_hit;
   logic              w_wr_hit;
   logic [IDX_W-1:0]  w_rd_idx;
   logic [IDX_W-1:0]  w_wr_idx;
   logic [IDX_W-1:0]  w_in_idx;
   logic [IDX_W-1:0]  w_out_idx;
   logic              w_in_fire;
   logic              w_out_fire;
   logic [CNT_W-1:0]  w_in_cnt_nxt;
   logic [CNT_W-1:0]  w_out_cnt_nxt;

   assign w_aud_sel = ~r_sel;
   assign w_rd_hit  = rd_en && ({1'b0, rd_addr} < N_CH_A);
   assign w_wr_hit  = wr_en && ({1'b0, wr_addr} < N_CH_A);
   assign w_rd_idx  = rd_addr[IDX_W-1:0];
   assign w_wr_idx  = wr_addr[IDX_W-1:0];
   assign w_in_idx  = r_in_cnt[IDX_W-1:0];
   assign w_out_idx = (r_out_cnt < N_CH_C) ? r_out_cnt[IDX_W-1:0] : '0;

   assign in_ready  = (r_in_cnt < N_CH_C);
   assign out_valid = r_drain_active && (r_out_cnt < N_CH_C);
   assign out_data  = r_out_mem[w_aud_sel][w_out_idx];
   assign rd_data   = r_rd_data;

   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;

   // Counts including a handshake in the frame_sync cycle itself.
   assign w_in_cnt_nxt  = r_in_cnt  + CNT_W'(w_in_fire);
   assign w_out_cnt_nxt = r_out_cnt + CNT_W'(w_out_fire);

   // NOTE: storage arrays have no reset so they map onto plain RAM; their
   // contents are undefined until written.
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_in_mem[w_aud_sel][w_in_idx] <= in_data;
      end
      if (w_wr_hit) begin
         r_out_mem[r_sel][w_wr_idx] <= wr_data;
      end
   end

   // Out-of-range reads return 0; rd_data holds while rd_en is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= w_rd_hit ? r_in_mem[r_sel][w_rd_idx] : '0;
      end
   end

   // NOTE: all sequential state uses non-blocking assignment so every
   // register samples pre-edge values, which keeps frame_sync-cycle events
   // on the pre-swap banks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sel          <= 1'b0;
         r_in_cnt       <= '0;
         r_out_cnt      <= '0;
         r_drain_active <= 1'b0;
      end else if (frame_sync) begin
         r_sel          <= ~r_sel;
         r_in_cnt       <= '0;
         r_out_cnt      <= '0;
         r_drain_active <= 1'b1;
      end else begin
         r_in_cnt  <= w_in_cnt_nxt;
         r_out_cnt <= w_out_cnt_nxt;
      end
   end

`ifdef IO_MEM_STATUS_EN
   logic r_err_in_short;
   logic r_err_out_late;
   logic w_set_short;
   logic w_set_late;

   assign w_set_short = frame_sync && (w_in_cnt_nxt < N_CH_C);
   assign w_set_late  = frame_sync && r_drain_active && (w_out_cnt_nxt < N_CH_C);

   // A set condition outranks err_clr in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_in_short <= 1'b0;
         r_err_out_late <= 1'b0;
      end else begin
         if (w_set_short) begin
            r_err_in_short <= 1'b1;
         end else if (err_clr) begin
            r_err_in_short <= 1'b0;
         end
         if (w_set_late) begin
            r_err_out_late <= 1'b1;
         end else if (err_clr) begin
            r_err_out_late <= 1'b0;
         end
      end
   end

   assign err_in_short = r_err_in_short;
   assign err_out_late = r_err_out_late;
`else
   logic w_unused_err_clr;

   assign w_unused_err_clr = err_clr;
   assign err_in_short     = 1'b0;
   assign err_out_late     = 1'b0;
`endif

endmodule

// File: tb/tb_io_mem_bank.sv
// Directed self-checking bench for io_mem_bank (N_CH = 16, DATA_W = 36).
module tb_io_mem_bank;

   localparam int DW = 36;
   localparam int AW = 10;
`ifdef IO_MEM_STATUS_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          frame_sync;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          err_in_short;
   logic          err_out_late;
   logic          err_clr;

   int n_tests = 0;
   int n_fail  = 0;

   io_mem_bank dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .frame_sync   (frame_sync),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .err_in_short (err_in_short),
      .err_out_late (err_out_late),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] w(input int v);
      return DW'(v);
   endfunction

   task automatic check_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      rd_en = 0; wr_en = 0; in_valid = 0; out_ready = 0;
      frame_sync = 0; err_clr = 0;
   endtask

   task automatic pulse_sync();
      frame_sync = 1;
      @(negedge clk);
      frame_sync = 0;
   endtask

   initial begin
      reset_n = 0; rd_addr = '0; wr_addr = '0; wr_data = '0; in_data = '0;
      idle_inputs();
      #12;
      check_w("rst_rd_data", rd_data, w(0));
      check_b("rst_in_ready", in_ready, 1'b1);
      check_b("rst_out_valid", out_valid, 1'b0);
      check_b("rst_err_short", err_in_short, 1'b0);
      check_b("rst_err_late", err_out_late, 1'b0);
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);

      // Frame 0 (sel=0): fill input bank 1 with 100.., write output bank 0 with -5-i.
      for (int i = 0; i < 16; i++) begin
         in_valid = 1; in_data = w(100 + i);
         wr_en = 1; wr_addr = AW'(i); wr_data = w(-5 - i);
         @(negedge clk);
      end
      wr_en = 0; in_valid = 1; in_data = w(999);
      check_b("in_full_ready", in_ready, 1'b0);
      check_b("predrain_out_valid", out_valid, 1'b0);
      @(negedge clk);
      check_b("in_full_ready_held", in_ready, 1'b0);
      in_valid = 0;
      pulse_sync();
      check_b("f0_err_short", err_in_short, 1'b0);
      check_b("f0_err_late", err_out_late, 1'b0);
      check_b("f0_in_ready", in_ready, 1'b1);

      // Frame 1 (sel=1): read 100..115, drain -5..-20 back-to-back.
      for (int i = 0; i < 16; i++) begin
         check_b($sformatf("f1_ov%0d", i), out_valid, 1'b1);
         check_w($sformatf("f1_od%0d", i), out_data, w(-5 - i));
         rd_en = 1; rd_addr = AW'(i);
         wr_en = 1; wr_addr = AW'(i); wr_data = w(200 + i);
         in_valid = 1; in_data = w(300 + i);
         out_ready = 1;
         @(negedge clk);
         check_w($sformatf("f1_rd%0d", i), rd_data, w(100 + i));
      end
      idle_inputs();
      check_b("f1_drain_done", out_valid, 1'b0);
      rd_en = 1; rd_addr = AW'(5);
      @(negedge clk);
      check_w("rd_addr5", rd_data, w(105));
      rd_en = 0; rd_addr = AW'(7);
      @(negedge clk);
      check_w("rd_hold", rd_data, w(105));
      rd_en = 1; rd_addr = AW'(20);
      @(negedge clk);
      check_w("rd_out_of_range", rd_data, w(0));
      rd_en = 0;
      pulse_sync();
      check_b("f1_err_short", err_in_short, 1'b0);
      check_b("f1_err_late", err_out_late, 1'b0);

      // Frame 2 (sel=0): drain 200.. with a 3-cycle stall before word 5.
      for (int i = 0; i < 16; i++) begin
         if (i == 5) begin
            idle_inputs();
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               check_b($sformatf("stall_ov%0d", s), out_valid, 1'b1);
               check_w($sformatf("stall_od%0d", s), out_data, w(205));
            end
         end
         check_w($sformatf("f2_od%0d", i), out_data, w(200 + i));
         wr_en = 1; wr_addr = AW'(i); wr_data = w(500 + i);
         in_valid = 1; in_data = w(400 + i);
         out_ready = 1;
         @(negedge clk);
      end
      idle_inputs();
      check_b("f2_drain_done", out_valid, 1'b0);
      pulse_sync();
      check_b("f2_err_short", err_in_short, 1'b0);
      check_b("f2_err_late", err_out_late, 1'b0);

      // Frame 3 (sel=1): only 10 inputs and 4 drained words -> short and late.
      for (int i = 0; i < 16; i++) begin
         if (i < 4) check_w($sformatf("f3_od%0d", i), out_data, w(500 + i));
         in_valid = (i < 10); in_data = w(600 + i);
         out_ready = (i < 4);
         wr_en = 1; wr_addr = AW'(i); wr_data = w(700 + i);
         @(negedge clk);
      end
      idle_inputs();
      check_b("f3_in_ready_open", in_ready, 1'b1);
      rd_en = 1; rd_addr = AW'(15);
      @(negedge clk);
      rd_en = 0;
      check_w("f3_rd15", rd_data, w(415));
      pulse_sync();
      check_b("short_set", err_in_short, EXP_ERR);
      check_b("late_set", err_out_late, EXP_ERR);
      check_b("short_in_ready", in_ready, 1'b1);
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
      check_b("short_clr", err_in_short, 1'b0);
      check_b("late_clr", err_out_late, 1'b0);

      // Frame 4 (sel=0): stale-channel reads, full drain, 15 inputs then boundary cycle.
      rd_en = 1; rd_addr = AW'(9);
      @(negedge clk);
      check_w("f4_rd9", rd_data, w(609));
      rd_addr = AW'(12);
      @(negedge clk);
      check_w("f4_rd12_stale", rd_data, w(312));
      rd_en = 0;
      for (int i = 0; i < 16; i++) begin
         check_w($sformatf("f4_od%0d", i), out_data, w(700 + i));
         in_valid = (i < 15); in_data = w(800 + i);
         out_ready = 1;
         @(negedge clk);
      end
      idle_inputs();
      check_b("bnd_in_ready", in_ready, 1'b1);
      in_valid = 1; in_data = w(815);
      wr_en = 1; wr_addr = AW'(3); wr_data = w(999);
      rd_en = 1; rd_addr = AW'(20);
      pulse_sync();
      idle_inputs();
      check_w("bnd_rd_zero", rd_data, w(0));
      check_b("bnd_no_short", err_in_short, 1'b0);
      check_b("bnd_no_late", err_out_late, 1'b0);
      check_b("bnd_sel", dut.r_sel, 1'b1);

      // Frame 5 (sel=1): boundary sample and boundary write land as expected.
      rd_en = 1; rd_addr = AW'(15);
      @(negedge clk);
      check_w("f5_rd15_boundary", rd_data, w(815));
      rd_addr = AW'(14);
      @(negedge clk);
      check_w("f5_rd14", rd_data, w(814));
      rd_en = 0;
      for (int i = 0; i < 16; i++) begin
         if (i < 4) check_w($sformatf("f5_od%0d", i), out_data, (i == 3) ? w(999) : w(500 + i));
         in_valid = 1; in_data = w(900 + i);
         out_ready = (i < 4);
         @(negedge clk);
      end
      idle_inputs();
      check_b("f5_in_full", in_ready, 1'b0);
      check_b("f5_mid_ov", out_valid, 1'b1);
      check_w("f5_mid_od", out_data, w(504));

      // Asynchronous reset mid-drain, away from any clock edge.
      #2 reset_n = 0;
      #1;
      check_b("arst_out_valid", out_valid, 1'b0);
      check_b("arst_in_ready", in_ready, 1'b1);
      check_w("arst_rd_data", rd_data, w(0));
      check_b("arst_sel", dut.r_sel, 1'b0);
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);

      // Back-to-back frame_sync pulses each swap.
      frame_sync = 1;
      @(negedge clk);
      check_b("dbl_sync_first", dut.r_sel, 1'b1);
      @(negedge clk);
      frame_sync = 0;
      check_b("dbl_sync_second", dut.r_sel, 1'b0);
      check_b("dbl_sync_drain", out_valid, 1'b1);
      check_b("dbl_sync_short", err_in_short, EXP_ERR);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
